// File: rtl/beat_serializer.sv
// Word-to-beat serializer: accepts a DATA_W word on a valid/ready handshake and presents it
// as DATA_W/BEAT_W registered beats with index/last framing, backpressure and flush.
module beat_serializer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BEAT_W    = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned BEATS    = DATA_W / BEAT_W,
    localparam int unsigned IDX_W    = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_index,
    output logic              busy
);

    typedef enum logic {StIdle, StShift} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BEATS - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                valid_q, valid_d;
    logic [BEAT_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                xfer;
    logic                accept;

    // The beat to present next always sits at the "front" end of the word/shift register.
    function automatic logic [BEAT_W-1:0] front_beat(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) begin
            return w[DATA_W-1 -: BEAT_W];
        end
        return w[BEAT_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] drop_beat(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) begin
            return w << BEAT_W;
        end
        return w >> BEAT_W;
    endfunction

    assign xfer     = valid_q & out_ready;
    assign in_ready = rst_n & ~flush & ((state_q == StIdle) | (xfer & last_q));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        index_d = index_q;
        if (flush) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
            index_d = '0;
        end else if (accept) begin
            // Covers both an idle load and a zero-bubble reload on the final beat.
            state_d = StShift;
            valid_d = 1'b1;
            data_d  = front_beat(in_data);
            shift_d = drop_beat(in_data);
            index_d = '0;
            last_d  = 1'b0;
        end else if (xfer) begin
            if (last_q) begin
                state_d = StIdle;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                data_d  = front_beat(shift_q);
                shift_d = drop_beat(shift_q);
                index_d = index_q + 1'b1;
                last_d  = (index_d == LastIdx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            index_q <= index_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_index = index_q;
    assign busy      = (state_q == StShift);

endmodule

// File: tb/tb_beat_serializer.sv
// Scoreboard bench for beat_serializer: default 32/8 LSB-first instance plus a 24/4 MSB-first one.
module tb_beat_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance 1: DATA_W=32, BEAT_W=8, LSB first
    logic        flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [31:0] in_data1 = '0;
    logic        in_ready1, out_valid1, out_last1, busy1;
    logic [7:0]  out_data1;
    logic [1:0]  out_index1;

    // Instance 2: DATA_W=24, BEAT_W=4, MSB first
    logic        flush2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic [23:0] in_data2 = '0;
    logic        in_ready2, out_valid2, out_last2, busy2;
    logic [3:0]  out_data2;
    logic [2:0]  out_index2;

    beat_serializer u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out_ready(out_ready1), .out_valid(out_valid1),
        .out_data(out_data1), .out_last(out_last1), .out_index(out_index1), .busy(busy1)
    );

    beat_serializer #(.DATA_W(24), .BEAT_W(4), .MSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .out_ready(out_ready2), .out_valid(out_valid2),
        .out_data(out_data2), .out_last(out_last2), .out_index(out_index2), .busy(busy2)
    );

    // Expected beats {data, index, last}, oldest first
    logic [10:0] sb1[$];
    logic [7:0]  sb2[$];
    int left1 = 0;   // beats of the held word not yet taken by the sink
    int left2 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] beat1(input logic [31:0] w, input int i);
        return 8'(w >> (8 * i));
    endfunction

    function automatic logic [3:0] beat2(input logic [23:0] w, input int i);
        return 4'(w >> (24 - 4 * (i + 1)));
    endfunction

    task automatic cyc1(input logic v, input logic [31:0] d, input logic r, input logic f);
        logic rdy;
        @(posedge clk);
        #1;
        in_valid1 = v; in_data1 = d; out_ready1 = r; flush1 = f;
        #1;
        rdy = !f && (left1 == 0 || (left1 == 1 && r));
        check("in_ready1", 64'(in_ready1), 64'(rdy));
        check("out_valid1", 64'(out_valid1), 64'(left1 != 0));
        check("busy1", 64'(busy1), 64'(left1 != 0));
        if (left1 == 0) check("last_idle1", 64'(out_last1), 64'(0));
        if (f) begin
            sb1.delete();
            left1 = 0;
        end else begin
            if (r && left1 != 0) left1--;
            if (v && rdy) begin
                for (int i = 0; i < 4; i++) sb1.push_back({beat1(d, i), 2'(i), i == 3});
                left1 = 4;
            end
        end
    endtask

    task automatic cyc2(input logic v, input logic [23:0] d, input logic r, input logic f);
        logic rdy;
        @(posedge clk);
        #1;
        in_valid2 = v; in_data2 = d; out_ready2 = r; flush2 = f;
        #1;
        rdy = !f && (left2 == 0 || (left2 == 1 && r));
        check("in_ready2", 64'(in_ready2), 64'(rdy));
        check("out_valid2", 64'(out_valid2), 64'(left2 != 0));
        check("busy2", 64'(busy2), 64'(left2 != 0));
        if (f) begin
            sb2.delete();
            left2 = 0;
        end else begin
            if (r && left2 != 0) left2--;
            if (v && rdy) begin
                for (int i = 0; i < 6; i++) sb2.push_back({beat2(d, i), 3'(i), i == 5});
                left2 = 6;
            end
        end
    endtask

    // Monitors: every beat the sink takes must be the oldest expected beat.
    logic [10:0] e1;
    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1 && !flush1) begin
            if (sb1.size() == 0) begin
                check("beat1_unexpected", 64'({out_data1, out_index1, out_last1}), 64'hFFFF);
            end else begin
                e1 = sb1.pop_front();
                check("beat1", 64'({out_data1, out_index1, out_last1}), 64'(e1));
            end
        end
    end

    logic [7:0] e2;
    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2 && !flush2) begin
            if (sb2.size() == 0) begin
                check("beat2_unexpected", 64'({out_data2, out_index2, out_last2}), 64'hFFFF);
            end else begin
                e2 = sb2.pop_front();
                check("beat2", 64'({out_data2, out_index2, out_last2}), 64'(e2));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a pending word
        in_valid1 = 1'b1;
        in_data1  = 32'h12345678;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid1), 64'(0));
        check("rst_out_data", 64'(out_data1), 64'(0));
        check("rst_in_ready", 64'(in_ready1), 64'(0));
        check("rst_busy", 64'(busy1), 64'(0));
        @(negedge clk);
        in_valid1 = 1'b0;
        rst_n = 1'b1;
        cyc1(1'b0, '0, 1'b1, 1'b0);
        cyc1(1'b0, '0, 1'b1, 1'b0);

        // Single word, continuous ready
        cyc1(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        repeat (5) cyc1(1'b0, '0, 1'b1, 1'b0);

        // Back-to-back words with in_valid held
        cyc1(1'b1, 32'h11223344, 1'b1, 1'b0);
        repeat (4) cyc1(1'b1, 32'h55667788, 1'b1, 1'b0);
        repeat (5) cyc1(1'b0, '0, 1'b1, 1'b0);

        // Backpressure while beat 2 is shown
        cyc1(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        cyc1(1'b0, '0, 1'b1, 1'b0);
        cyc1(1'b0, '0, 1'b1, 1'b0);
        repeat (3) begin
            cyc1(1'b1, 32'h0BADF00D, 1'b0, 1'b0);
            check("stall_data", 64'(out_data1), 64'(8'hAD));
            check("stall_index", 64'(out_index1), 64'(2));
        end
        repeat (4) cyc1(1'b0, '0, 1'b1, 1'b0);

        // Flush after the second beat; new word follows immediately
        cyc1(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        cyc1(1'b0, '0, 1'b1, 1'b0);
        cyc1(1'b0, '0, 1'b1, 1'b0);
        cyc1(1'b1, 32'h99999999, 1'b1, 1'b1);
        cyc1(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        repeat (5) cyc1(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc1(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 24) == 0));
        end
        repeat (8) cyc1(1'b0, '0, 1'b1, 1'b0);
        check("sb1_drained", 64'(sb1.size()), 64'(0));

        // Reset asserted mid-word
        cyc1(1'b1, 32'hA5A5C3C3, 1'b1, 1'b0);
        cyc1(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid1 = 1'b0;
        sb1.delete();
        left1 = 0;
        #1;
        check("midrst_out_valid", 64'(out_valid1), 64'(0));
        check("midrst_out_data", 64'(out_data1), 64'(0));
        check("midrst_in_ready", 64'(in_ready1), 64'(0));
        check("midrst_busy", 64'(busy1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc1(1'b1, 32'h01020304, 1'b1, 1'b0);
        repeat (5) cyc1(1'b0, '0, 1'b1, 1'b0);
        check("sb1_after_rst", 64'(sb1.size()), 64'(0));

        // MSB-first 24/4 instance
        cyc2(1'b1, 24'hABC123, 1'b1, 1'b0);
        repeat (7) cyc2(1'b0, '0, 1'b1, 1'b0);
        for (int n = 0; n < 300; n++) begin
            cyc2(($urandom_range(0, 3) != 0), 24'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 30) == 0));
        end
        repeat (10) cyc2(1'b0, '0, 1'b1, 1'b0);
        check("sb2_drained", 64'(sb2.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
